// File: rtl/priority_arb_pkg.sv
// Shared types and helpers for the registered N-input priority arbiter.
// Holds the FSM state encoding, the legal N range and the grant decoder.
package priority_arb_pkg;

  localparam int MIN_N = 2;
  localparam int MAX_N = 32;
  localparam int IDX_W = $clog2(MAX_N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Decodes an index into a MAX_N-wide one-hot; callers truncate to their own N.
  function automatic logic [MAX_N-1:0] one_hot(input logic [IDX_W-1:0] idx);
    logic [MAX_N-1:0] base;
    base = {{(MAX_N-1){1'b0}}, 1'b1};
    return base << idx;
  endfunction

endpackage

// File: rtl/rotate_pick.sv
// Combinational search over a request vector, starting at index start and walking
// downward with wrap from 0 to N-1; reports the first set bit found.
module rotate_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W-1:0] pos;

  // Scan from the farthest offset to the nearest so the nearest hit is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (off <= int'(start)) begin
        pos = start - W'(off);
      end else begin
        pos = start + W'(N - off);
      end
      if (req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_arb_n.sv
// Registered N-input arbiter: grants one requester and holds it until i_done, request drop
// or hold timeout. Define PRIORITY_ARB_RR_EN for round-robin; otherwise fixed highest-index-first.
module priority_arb_n
  import priority_arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 0,
  localparam int W        = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_req,
  input  logic         i_done,
  output logic [W-1:0] o_code,
  output logic [N-1:0] o_gnt,
  output logic         o_valid
);

  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  if (N < MIN_N || N > MAX_N) begin : g_bad_n
    $error("priority_arb_n: N out of range");
  end

  arb_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic [N-1:0]  pick_req;
  logic [N-1:0]  win_oh;
  logic [W-1:0]  start;
  logic [W-1:0]  win;
  logic          found;
  logic          timeout;
  logic          release_now;
  logic          arbitrate;

`ifdef PRIORITY_ARB_RR_EN
  logic [W-1:0] ptr;
  assign start = ptr;
`else
  assign start = W'(N - 1);
`endif

  // The current holder is masked out of the arbitration that replaces it.
  assign pick_req = (state == GRANT) ? (i_req & ~o_gnt) : i_req;

  rotate_pick #(
    .N(N)
  ) u_pick (
    .req   (pick_req),
    .start (start),
    .idx   (win),
    .found (found)
  );

  assign win_oh = N'(one_hot(IDX_W'(win)));

  // Timeout fires on the edge that completes the MAX_HOLD-th granted cycle.
  assign timeout     = (MAX_HOLD != 0) && ((hold_cnt + HW'(1)) == HW'(MAX_HOLD));
  assign release_now = i_done || ((i_req & o_gnt) == '0) || timeout;
  assign arbitrate   = (state == IDLE) || release_now;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      o_valid  <= 1'b0;
      o_code   <= '0;
      o_gnt    <= '0;
      hold_cnt <= '0;
`ifdef PRIORITY_ARB_RR_EN
      ptr      <= W'(N - 1);
`endif
    end else if (arbitrate) begin
      if (found) begin
        state    <= GRANT;
        o_valid  <= 1'b1;
        o_code   <= win;
        o_gnt    <= win_oh;
        hold_cnt <= '0;
`ifdef PRIORITY_ARB_RR_EN
        ptr      <= (win == '0) ? W'(N - 1) : (win - W'(1));
`endif
      end else begin
        state   <= IDLE;
        o_valid <= 1'b0;
        o_code  <= '0;
        o_gnt   <= '0;
      end
    end else begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

endmodule

// File: tb/tb_priority_arb_n.sv
// Directed bench for priority_arb_n (N=4): one instance with MAX_HOLD=3, one without timeout.
// Expectations follow PRIORITY_ARB_RR_EN when it is defined for the build.
module tb_priority_arb_n;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] code;
  logic [3:0] gnt;
  logic       valid;
  logic [1:0] code_nh;
  logic [3:0] gnt_nh;
  logic       valid_nh;

  int n_pass;
  int n_total;

  priority_arb_n #(.N(4), .MAX_HOLD(3)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_done  (done),
    .o_code  (code),
    .o_gnt   (gnt),
    .o_valid (valid)
  );

  priority_arb_n #(.N(4), .MAX_HOLD(0)) dut_nh (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_done  (done),
    .o_code  (code_nh),
    .o_gnt   (gnt_nh),
    .o_valid (valid_nh)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_total++;
      if ({valid, code, gnt} !== 7'b0)
        $display("FAIL reset_outs cycle %0d: got v=%0b c=%0d g=%b want all zero", c, valid, code, gnt);
      else n_pass++;
    end
    rst_n = 1'b1;
    tick();
    n_total++;
    if ({valid, code, gnt} !== {1'b1, 2'd3, 4'b1000})
      $display("FAIL reset_first_grant: got v=%0b c=%0d g=%b want v=1 c=3 g=1000", valid, code, gnt);
    else n_pass++;
  endtask

  task automatic test_fixed();
    do_reset();
    req = 4'b0110;
    tick();
    n_total++;
    if ({valid, code, gnt} !== {1'b1, 2'd2, 4'b0100})
      $display("FAIL fixed_grant: got v=%0b c=%0d g=%b want v=1 c=2 g=0100", valid, code, gnt);
    else n_pass++;
    tick();
    n_total++;
    if ({valid, code, gnt} !== {1'b1, 2'd2, 4'b0100})
      $display("FAIL fixed_hold: got v=%0b c=%0d g=%b want v=1 c=2 g=0100", valid, code, gnt);
    else n_pass++;
    done = 1'b1;
    tick();
    done = 1'b0;
    n_total++;
    if ({valid, code, gnt} !== {1'b1, 2'd1, 4'b0010})
      $display("FAIL fixed_no_bubble: got v=%0b c=%0d g=%b want v=1 c=1 g=0010", valid, code, gnt);
    else n_pass++;
    // i_done together with a request drop is a single release
    do_reset();
    req = 4'b0110;
    tick();
    req  = 4'b0010;
    done = 1'b1;
    tick();
    done = 1'b0;
    n_total++;
    if ({valid, code} !== {1'b1, 2'd1})
      $display("FAIL done_and_drop: got v=%0b c=%0d want v=1 c=1", valid, code);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_seq [4];
`ifdef PRIORITY_ARB_RR_EN
    exp_seq = '{2'd2, 2'd1, 2'd0, 2'd3};
`else
    exp_seq = '{2'd2, 2'd3, 2'd2, 2'd3};
`endif
    do_reset();
    req = 4'b1111;
    tick();
    n_total++;
    if (code !== 2'd3) $display("FAIL b2b_first: got c=%0d want 3", code);
    else n_pass++;
    done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if ({valid, code} !== {1'b1, exp_seq[i]})
        $display("FAIL b2b_seq[%0d]: got v=%0b c=%0d want v=1 c=%0d", i, valid, code, exp_seq[i]);
      else n_pass++;
    end
    done = 1'b0;
  endtask

  task automatic test_timeout();
    logic exp_v [6];
    exp_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    req = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++;
      if (valid !== exp_v[i] || (exp_v[i] && code !== 2'd3))
        $display("FAIL timeout[%0d]: got v=%0b c=%0d want v=%0b c=3", i, valid, code, exp_v[i]);
      else n_pass++;
      n_total++;
      if ({valid_nh, code_nh} !== {1'b1, 2'd3})
        $display("FAIL no_timeout[%0d]: got v=%0b c=%0d want v=1 c=3", i, valid_nh, code_nh);
      else n_pass++;
    end
  endtask

  task automatic test_timeout_done();
    do_reset();
    req = 4'b1100;
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    n_total++;
    if ({valid, code} !== {1'b1, 2'd2})
      $display("FAIL timeout_with_done: got v=%0b c=%0d want v=1 c=2", valid, code);
    else n_pass++;
    tick();
    n_total++;
    if ({valid, code} !== {1'b1, 2'd2})
      $display("FAIL timeout_with_done_hold: got v=%0b c=%0d want v=1 c=2", valid, code);
    else n_pass++;
  endtask

  task automatic test_req_drop();
    do_reset();
    req = 4'b0010;
    tick();
    n_total++;
    if ({valid, code} !== {1'b1, 2'd1})
      $display("FAIL drop_grant: got v=%0b c=%0d want v=1 c=1", valid, code);
    else n_pass++;
    req = 4'b0000;
    tick();
    n_total++;
    if ({valid, gnt} !== {1'b0, 4'b0000})
      $display("FAIL drop_release: got v=%0b g=%b want v=0 g=0000", valid, gnt);
    else n_pass++;
    done = 1'b1;
    tick();
    n_total++;
    if ({valid, gnt} !== {1'b0, 4'b0000})
      $display("FAIL idle_done: got v=%0b g=%b want v=0 g=0000", valid, gnt);
    else n_pass++;
    req = 4'b0100;
    tick();
    done = 1'b0;
    n_total++;
    if ({valid, code, gnt} !== {1'b1, 2'd2, 4'b0100})
      $display("FAIL idle_done_with_req: got v=%0b c=%0d g=%b want v=1 c=2 g=0100", valid, code, gnt);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0100;
    tick();
    n_total++;
    if (code !== 2'd2) $display("FAIL mid_reset_pre: got c=%0d want 2", code);
    else n_pass++;
    rst_n = 1'b0;
    req   = 4'b1111;
    tick();
    rst_n = 1'b1;
    n_total++;
    if ({valid, code, gnt} !== 7'b0)
      $display("FAIL mid_reset_outs: got v=%0b c=%0d g=%b want all zero", valid, code, gnt);
    else n_pass++;
    tick();
    n_total++;
    if ({valid, code, gnt} !== {1'b1, 2'd3, 4'b1000})
      $display("FAIL mid_reset_regrant: got v=%0b c=%0d g=%b want v=1 c=3 g=1000", valid, code, gnt);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    done    = 1'b0;
    test_reset();
    test_fixed();
    test_back_to_back();
    test_timeout();
    test_timeout_done();
    test_req_drop();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
